two_phase_tx: RTL and testbench

Clocked transmitter for the two-phase (transition-signalling) handshake used by the async primitives. It accepts words from a synchronous valid/ready stream and emits each word as bundled data plus one transition on req. It then waits for the matching transition on ack before accepting the next word. It sits at the sync-to-async boundary and drives the req input of a toggle-based pipeline stage; that stage steers alternate req transitions onto its two outputs.

---
 rtl/two_phase_pkg.sv | 26 ++
 rtl/two_phase_sync_ff.sv | 33 +++
 rtl/two_phase_tx.sv | 145 ++++++++++++++
 tb/tb_two_phase_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/two_phase_pkg.sv
// rtl/two_phase_pkg.sv - shared types for the two-phase handshake blocks
//
// Purpose: state encoding for the transmitter FSM and the one-hot phase
// codes that tell the toggle-side stage which output the last req
// transition lands on. Also a small width helper for saturating counters.
// Ports: none (package).
package two_phase_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [1:0] PH_NONE = 2'b00;
  localparam logic [1:0] PH_EVEN = 2'b01;
  localparam logic [1:0] PH_ODD  = 2'b10;

  // Bits needed to hold 0..max_val; never less than 1 so a disabled
  // (zero) limit still yields a legal vector.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/two_phase_sync_ff.sv
// rtl/two_phase_sync_ff.sv - multi-flop synchronizer for asynchronous inputs
//
// Purpose: STAGES-deep flop chain that brings an asynchronous signal into
// the clk domain. Synchronous active-low reset clears every stage.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-low reset
//   d    - asynchronous input
//   q    - synchronized output (last stage)
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/two_phase_tx.sv
// rtl/two_phase_tx.sv - valid/ready to two-phase req/ack transmitter
//
// Purpose: accepts words from a synchronous valid/ready stream, presents
// each as bundled data, toggles req once per word after a setup margin and
// waits for the matching ack transition before taking the next word.
// Ports:
//   clk, rst     - clock; synchronous active-low reset
//   in_data      - word to transmit (sampled only on accept)
//   in_valid     - in_data is valid
//   in_ready     - block accepts a word this cycle
//   data         - bundled data toward the async stage
//   req          - two-phase request, one transition per word
//   ack          - two-phase acknowledge, asynchronous to clk
//   phase        - one-hot target of the last req transition
//   busy         - word in flight (SETUP or WAIT_ACK)
//   timeout_err  - sticky; ack missing or protocol violation, reset to clear
module two_phase_tx
  import two_phase_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SETUP_CYC   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data,
  output logic              req,
  input  logic              ack,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              timeout_err
);

  localparam int SCW = cnt_w(SETUP_CYC);
  localparam int TCW = cnt_w(TIMEOUT);
  // Setup counter runs SETUP_CYC-1 down to 0, so SETUP lasts SETUP_CYC cycles.
  localparam logic [SCW-1:0] SETUP_LOAD = SCW'(SETUP_CYC - 1);
  // Counter value during the TIMEOUT-th WAIT_ACK cycle.
  localparam logic [TCW-1:0] TC_LAST = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TCW-1:0] TC_MAX  = '1;

  state_t            state, state_n;
  logic [DATA_W-1:0] data_n;
  logic              req_n;
  logic [1:0]        phase_n;
  logic [SCW-1:0]    scnt, scnt_n;
  logic [TCW-1:0]    tcnt, tcnt_n;
  logic              err_n;
  logic              ack_s;
  logic              ack_match;

  sync_ff #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );

  assign ack_match = (ack_s == req);

  always_comb begin
    state_n  = state;
    data_n   = data;
    req_n    = req;
    phase_n  = phase;
    scnt_n   = scnt;
    tcnt_n   = tcnt;
    err_n    = timeout_err;
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        // An ack edge with no request outstanding would make the next req
        // complete instantly; treat it as a protocol error. in_ready is
        // withheld in that cycle so no accepted word is lost.
        if (!ack_match) begin
          state_n = ERR;
          err_n   = 1'b1;
        end else begin
          in_ready = rst;
          if (in_valid) begin
            data_n  = in_data;
            scnt_n  = SETUP_LOAD;
            state_n = SETUP;
          end
        end
      end
      SETUP: begin
        busy = 1'b1;
        if (scnt == '0) begin
          req_n   = ~req;
          // New req level 1 means an odd number of transitions so far.
          phase_n = req ? PH_EVEN : PH_ODD;
          tcnt_n  = '0;
          state_n = WAIT_ACK;
        end else begin
          scnt_n = scnt - 1'b1;
        end
      end
      WAIT_ACK: begin
        busy = 1'b1;
        if (ack_match) begin
          state_n = IDLE;
        end else if (TIMEOUT != 0 && tcnt == TC_LAST) begin
          state_n = ERR;
          err_n   = 1'b1;
        end else if (tcnt != TC_MAX) begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      ERR: begin
        // Frozen until reset; late acks are ignored.
      end
      default: state_n = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      data        <= '0;
      req         <= 1'b0;
      phase       <= PH_NONE;
      scnt        <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      data        <= data_n;
      req         <= req_n;
      phase       <= phase_n;
      scnt        <= scnt_n;
      tcnt        <= tcnt_n;
      timeout_err <= err_n;
    end
  end

endmodule

// File: tb/tb_two_phase_tx.sv
// tb/tb_two_phase_tx.sv - scoreboard bench for two_phase_tx
module tb_two_phase_tx;

  localparam int DATA_W      = 8;
  localparam int SETUP_CYC   = 1;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] data;
  logic              req;
  logic              ack;
  logic              ack_a = 1'b0;
  logic              ack_m = 1'b0;
  logic [1:0]        phase;
  logic              busy;
  logic              timeout_err;

  assign ack = ack_a ^ ack_m;

  int  total = 0;
  int  bad   = 0;
  int  ntog  = 0;
  bit  ack_auto = 1'b0;
  int  ack_dly  = 1;
  logic [DATA_W+1:0] exp_q [$];

  always #5 clk = ~clk;

  two_phase_tx #(
    .DATA_W      (DATA_W),
    .SETUP_CYC   (SETUP_CYC),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data        (data),
    .req         (req),
    .ack         (ack),
    .phase       (phase),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k-th transition since reset: req starts at 0, so odd counts land on 2'b10.
  function automatic logic [1:0] exp_phase(input int n);
    if (n == 0) return 2'b00;
    return (n % 2 == 1) ? 2'b10 : 2'b01;
  endfunction

  // Monitor: every req transition must deliver the next scoreboard word.
  initial begin : monitor
    logic              prev_req;
    logic [DATA_W+1:0] e;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        prev_req = 1'b0;
      end else if (req !== prev_req) begin
        prev_req = req;
        if (exp_q.size() == 0) begin
          check("req_without_word", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("word_data", data, e[DATA_W+1:2]);
          check("word_phase", phase, e[1:0]);
        end
      end
    end
  end

  // Async partner: answers a req transition after ack_dly cycles when enabled.
  initial begin : ack_agent
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ack_a = 1'b0;
        wcnt  = 0;
      end else if (ack_auto && req !== ack) begin
        wcnt++;
        if (wcnt >= ack_dly) begin
          ack_a = ~ack_a;
          wcnt  = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    ack_m = 1'b0;
    exp_q.delete();
    ntog = 0;
    repeat (cyc) @(negedge clk);
    rst = 1'b1;
  endtask

  // Offers one word; returns just after the accepting clock edge.
  task automatic send(input logic [DATA_W-1:0] w);
    int n;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_bound", 32'(in_ready), 1);
    end else begin
      @(posedge clk);
      ntog++;
      exp_q.push_back({w, exp_phase(ntog)});
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(in_ready), 1);
  endtask

  initial begin : main
    // 1. reset state and release
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_req", 32'(req), 0);
    check("rst_data", 32'(data), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(timeout_err), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 1);
    check("rel_req", 32'(req), 0);
    check("rel_busy", 32'(busy), 0);

    // 2. single word, manual ack three cycles after the req edge
    send(8'hA5);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_data", 32'(data), 32'hA5);
    check("lat_req_held", 32'(req), 0);
    check("lat_busy", 32'(busy), 1);
    check("lat_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    check("lat_req_edge", 32'(req), 1);
    check("lat_phase", 32'(phase), 32'(2'b10));
    repeat (3) @(negedge clk);
    ack_m = ~ack_m;
    repeat (SYNC_STAGES) @(negedge clk);
    check("ack_ready_early", 32'(in_ready), 0);
    check("ack_busy_early", 32'(busy), 1);
    @(negedge clk);
    check("ack_ready", 32'(in_ready), 1);
    check("ack_busy_done", 32'(busy), 0);

    // 3. back-to-back stream with prompt acks
    ack_auto = 1'b1;
    ack_dly  = 1;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("stream_idle");
    check("stream_drained", exp_q.size(), 0);
    check("stream_req", 32'(req), 32'(ntog % 2));

    // randomized words, gaps and ack delays
    for (int i = 0; i < 24; i++) begin
      ack_dly = $urandom_range(1, 5);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      send(DATA_W'($urandom));
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("rand_idle");
    check("rand_drained", exp_q.size(), 0);
    check("rand_req", 32'(req), 32'(ntog % 2));
    check("rand_phase", 32'(phase), 32'(exp_phase(ntog)));

    // 4. no ack: timeout after TIMEOUT cycles of WAIT_ACK, late ack ignored
    ack_auto = 1'b0;
    send(8'h3C);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("to_err_before", 32'(timeout_err), 0);
    check("to_busy_before", 32'(busy), 1);
    @(negedge clk);
    check("to_err", 32'(timeout_err), 1);
    check("to_busy", 32'(busy), 0);
    check("to_in_ready", 32'(in_ready), 0);
    ack_m = ~ack_m;
    repeat (6) @(negedge clk);
    check("late_err", 32'(timeout_err), 1);
    check("late_in_ready", 32'(in_ready), 0);
    check("late_req", 32'(req), 32'(ntog % 2));
    check("late_data", 32'(data), 32'h3C);

    // 5. reset pulse in the middle of WAIT_ACK
    do_reset(2);
    @(negedge clk);
    check("clr_err", 32'(timeout_err), 0);
    check("clr_in_ready", 32'(in_ready), 1);
    send(8'h77);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_req", 32'(req), 1);
    rst = 1'b0;
    exp_q.delete();
    ntog = 0;
    @(negedge clk);
    check("mid_rst_req", 32'(req), 0);
    check("mid_rst_data", 32'(data), 0);
    check("mid_rst_err", 32'(timeout_err), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_phase", 32'(phase), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", 32'(in_ready), 1);

    // 6. spurious ack while idle with req=0
    ack_m = ~ack_m;
    @(negedge clk);
    check("sp_ready_1", 32'(in_ready), 1);
    @(negedge clk);
    check("sp_err_early", 32'(timeout_err), 0);
    check("sp_ready_2", 32'(in_ready), 0);
    @(negedge clk);
    check("sp_err", 32'(timeout_err), 1);
    check("sp_in_ready", 32'(in_ready), 0);
    check("sp_busy", 32'(busy), 0);
    check("sp_req", 32'(req), 0);

    do_reset(2);
    @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
